// File: rtl/cmp_arbiter_if.sv
// rtl/cmp_arbiter_if.sv - request/response bundle for the four-requester bit-serial comparator arbiter.
interface cmp_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [4*WIDTH-1:0] req_a;
  logic [4*WIDTH-1:0] req_b;
  logic [3:0]         req_signed;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic               rsp_gt;
  logic               rsp_lt;
  logic               rsp_eq;
  logic               busy;

  modport slave (
    input  req_valid, req_a, req_b, req_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, busy
  );
endinterface

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter feeding an MSB-first bit-serial magnitude comparator.
module cmp_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  cmp_arbiter_if.slave  bus
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [1:0]       id_q, id_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic [1:0]       gnt_idx;
  logic             gnt_any;
  logic             bit_a, bit_b, bit_gt, bit_lt;

  // Walk offsets from the far end so the requester nearest ptr wins.
  always_comb begin
    gnt_idx = ptr_q;
    gnt_any = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req_valid[ptr_q + 2'(k)]) begin
        gnt_any = 1'b1;
        gnt_idx = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    bit_a  = a_q[idx_q];
    bit_b  = b_q[idx_q];
    bit_gt = bit_a & ~bit_b;
    bit_lt = ~bit_a & bit_b;
    // Sign bit set means negative, so it ranks below a clear sign bit.
    if (sgn_q && idx_q == IDX_MSB) begin
      bit_gt = ~bit_a & bit_b;
      bit_lt = bit_a & ~bit_b;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    id_d    = id_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d     = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
          b_d     = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
          sgn_d   = bus.req_signed[gnt_idx];
          id_d    = gnt_idx;
          idx_d   = IDX_MSB;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bit_gt || bit_lt) begin
          gt_d    = bit_gt;
          lt_d    = bit_lt;
          eq_d    = 1'b0;
          state_d = DONE;
        end else if (idx_q == '0) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          ptr_d   = id_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= IDX_MSB;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      id_q    <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      id_q    <= id_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE && gnt_any) ? (4'b0001 << gnt_idx) : 4'b0000;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_gt    = gt_q;
  assign bus.rsp_lt    = lt_q;
  assign bus.rsp_eq    = eq_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - self-checking bench for cmp_arbiter: directed vectors, corner sequences, random traffic.
module tb_cmp_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmp_arbiter_if #(.WIDTH(W)) bus();

  cmp_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  logic [W-1:0] op_a [4];
  logic [W-1:0] op_b [4];
  logic [3:0]   op_s;

  typedef struct {
    logic [3:0]   mask;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    int           hold;
    int           exp_id;
    int           exp_res;
    int           exp_n;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] mask);
    bus.req_valid  = mask;
    bus.req_signed = op_s;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*W +: W] = op_a[i];
      bus.req_b[i*W +: W] = op_b[i];
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < 4; i++) begin
      op_a[i] = W'($urandom);
      op_b[i] = W'($urandom);
    end
    op_s = 4'($urandom);
  endtask

  function automatic int model_grant(input logic [3:0] mask, input int p);
    for (int k = 0; k < 4; k++)
      if (mask[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Result from integer comparison; latency is the position of the highest differing bit.
  task automatic model_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           output int res, output int n);
    int va, vb;
    va = s ? int'($signed(a)) : int'({1'b0, a});
    vb = s ? int'($signed(b)) : int'({1'b0, b});
    res = (va > vb) ? 1 : (va < vb) ? -1 : 0;
    n = W;
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        n = W - i;
        break;
      end
    end
  endtask

  task automatic do_txn(input logic [3:0] mask, input int hold,
                        output int id_o, output int res, output int n);
    int g;
    logic [4:0] snap;
    drive(mask);
    #1;
    g = model_grant(mask, ptr_m);
    chk("grant_onehot", bus.req_ready, 4'b0001 << g);
    @(posedge clk);
    @(negedge clk);
    scramble();
    drive(mask);
    n = 0;
    while (!bus.rsp_valid && n < 4 * W) begin
      chk("ready_in_scan", bus.req_ready, 0);
      chk("busy_in_scan", bus.busy, 1);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("rsp_valid_seen", bus.rsp_valid, 1);
    id_o = bus.rsp_id;
    res = bus.rsp_gt ? 1 : (bus.rsp_lt ? -1 : 0);
    chk("result_onehot", int'(bus.rsp_gt) + int'(bus.rsp_lt) + int'(bus.rsp_eq), 1);
    snap = {bus.rsp_id, bus.rsp_gt, bus.rsp_lt, bus.rsp_eq};
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_stable", {bus.rsp_id, bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}, snap);
      chk("hold_no_grant", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0000;
    chk("idle_after_ack", bus.rsp_valid, 0);
    chk("busy_after_ack", bus.busy, 0);
    if (g >= 0) ptr_m = (g + 1) % 4;
  endtask

  initial begin
    vec_t vecs[$];
    int id_o, res, n, e_res, e_n, g, cnt;
    int grants[$];
    logic [3:0] mask;

    bus.req_valid  = 4'b0000;
    bus.rsp_ready  = 1'b0;
    bus.req_signed = 4'b0000;
    bus.req_a      = '0;
    bus.req_b      = '0;

    vecs.push_back('{4'b0100, 8'h80, 8'h00, 1'b0, 0, 2,  1, 1});
    vecs.push_back('{4'b0100, 8'h80, 8'h00, 1'b1, 0, 2, -1, 1});
    vecs.push_back('{4'b0100, 8'h5A, 8'h5A, 1'b0, 5, 2,  0, 8});
    vecs.push_back('{4'b0100, 8'h05, 8'h06, 1'b0, 0, 2, -1, 7});
    vecs.push_back('{4'b0001, 8'h7F, 8'h80, 1'b1, 2, 0,  1, 1});
    vecs.push_back('{4'b1000, 8'hFF, 8'hFE, 1'b1, 0, 3,  1, 8});
    vecs.push_back('{4'b0010, 8'h00, 8'h01, 1'b1, 1, 1, -1, 8});

    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_outputs", {bus.rsp_id, bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}, 0);
    chk("reset_ready", bus.req_ready, 0);
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);

    foreach (vecs[v]) begin
      for (int i = 0; i < 4; i++) begin
        op_a[i] = vecs[v].a;
        op_b[i] = vecs[v].b;
      end
      op_s = {4{vecs[v].sgn}};
      do_txn(vecs[v].mask, vecs[v].hold, id_o, res, n);
      chk($sformatf("vec%0d_id", v), id_o, vecs[v].exp_id);
      chk($sformatf("vec%0d_res", v), res, vecs[v].exp_res);
      chk($sformatf("vec%0d_lat", v), n, vecs[v].exp_n);
    end

    for (int t = 0; t < 40; t++) begin
      scramble();
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) op_b[i] = op_a[i] ^ W'(1 << $urandom_range(0, W - 1));
        else if ($urandom_range(0, 4) == 0) op_b[i] = op_a[i];
      mask = 4'($urandom_range(1, 15));
      g = model_grant(mask, ptr_m);
      model_cmp(op_a[g], op_b[g], op_s[g], e_res, e_n);
      do_txn(mask, $urandom_range(0, 3), id_o, res, n);
      chk("rand_id", id_o, g);
      chk("rand_res", res, e_res);
      chk("rand_lat", n, e_n);
    end

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    scramble();
    bus.rsp_ready = 1'b1;
    drive(4'hF);
    cnt = 0;
    while (grants.size() < 5 && cnt < 200) begin
      #1;
      if (bus.req_ready != 4'b0000) begin
        chk("rr_onehot", $countones(bus.req_ready), 1);
        for (int i = 0; i < 4; i++)
          if (bus.req_ready[i]) grants.push_back(i);
      end
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    chk("rr_grant_count", grants.size(), 5);
    for (int i = 0; i < grants.size() && i < 5; i++)
      chk($sformatf("rr_grant%0d", i), grants[i], i % 4);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0000;

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    do_txn(4'b0010, 0, id_o, res, n);
    chk("pre_abort_id", id_o, 1);
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 8'h5A;
      op_b[i] = 8'h5A;
    end
    drive(4'b0010);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_outputs", {bus.rsp_id, bus.rsp_gt, bus.rsp_lt, bus.rsp_eq}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      cnt += int'(bus.rsp_valid);
    end
    chk("abort_no_response", cnt, 0);
    scramble();
    g = model_grant(4'hF, ptr_m);
    model_cmp(op_a[g], op_b[g], op_s[g], e_res, e_n);
    do_txn(4'hF, 0, id_o, res, n);
    chk("post_reset_id", id_o, 0);
    chk("post_reset_res", res, e_res);
    chk("post_reset_lat", n, e_n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
